// File: rtl/wb8_slave_mux.sv
// wb8_slave_mux: Wishbone-8 address decoder and response mux for NSLAVES
// peripherals. Each slave matches by base and mask, and the lowest index wins.
// The block forces an ACK on a slave that never answers, applies a policy to
// unmapped addresses, and records the last error response.
module wb8_slave_mux #(
  parameter int                    NSLAVES      = 9,
  parameter logic [32*NSLAVES-1:0] BASES        = {NSLAVES{32'h0}},
  parameter logic [32*NSLAVES-1:0] MASKS        = {NSLAVES{32'h0}},
  parameter int                    TIMEOUT      = 255,
  parameter bit                    UNMAPPED_ACK = 1'b1,
  parameter logic [7:0]            DEFAULT_DAT  = 8'h00
) (
  input  logic                   I_wb_clk,
  input  logic                   I_reset,
  input  logic [31:0]            I_wb_adr,
  input  logic                   I_wb_stb,
  output logic [7:0]             O_wb_dat,
  output logic                   O_wb_ack,
  output logic [NSLAVES-1:0]     O_slv_stb,
  input  logic [8*NSLAVES-1:0]   I_slv_dat,
  input  logic [NSLAVES-1:0]     I_slv_ack,
  output logic                   O_err,
  output logic [7:0]             O_err_count,
  output logic [31:0]            O_err_adr
);

  localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value in the last WAIT cycle before the forced ACK.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_nxt_s;
  logic [31:0]       adr_r;
  logic [NSLAVES-1:0] hit_s;
  logic              hit_any_s;
  logic [SW-1:0]     sel_s;
  logic              forced_s;
  logic              err_resp_s;
  logic              err_r;
  logic [7:0]        err_count_r;
  logic [31:0]       err_adr_r;

  assign forced_s    = (state_r == ST_FORCE);
  assign O_err       = err_r;
  assign O_err_count = err_count_r;
  assign O_err_adr   = err_adr_r;

  // Per-slave address match against base under mask.
  always_comb begin
    hit_s = {NSLAVES{1'b0}};
    for (int i = 0; i < NSLAVES; i++) begin
      hit_s[i] = (((I_wb_adr ^ BASES[32*i +: 32]) & MASKS[32*i +: 32]) == 32'h0);
    end
  end

  // Priority encode the hits so that the lowest matching index is selected.
  always_comb begin
    sel_s     = {SW{1'b0}};
    hit_any_s = 1'b0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      sel_s     = hit_s[i] ? SW'(i) : sel_s;
      hit_any_s = hit_any_s | hit_s[i];
    end
  end

  // Response mux: forced ACK, then the selected slave, then the unmapped policy.
  always_comb begin
    O_slv_stb  = {NSLAVES{1'b0}};
    O_wb_ack   = 1'b0;
    O_wb_dat   = DEFAULT_DAT;
    err_resp_s = 1'b0;
    if (forced_s) begin
      // A late slave ACK in this cycle is deliberately ignored.
      O_wb_ack   = 1'b1;
      err_resp_s = 1'b1;
    end else if (hit_any_s) begin
      O_slv_stb[sel_s] = I_wb_stb;
      O_wb_ack         = I_slv_ack[sel_s];
      O_wb_dat         = I_slv_dat[{sel_s, 3'b000} +: 8];
    end else if (UNMAPPED_ACK) begin
      O_wb_ack   = I_wb_stb;
      err_resp_s = I_wb_stb;
    end else begin
      // Unmapped with no immediate ACK: the timeout completes the access.
      O_wb_ack = 1'b0;
    end
  end

  // Next-state and wait-counter logic. The counter holds the number of STB
  // cycles already spent on the current access, so FORCE lands on cycle TIMEOUT+1.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (I_wb_stb && !O_wb_ack) begin
          state_nxt_s = (TIMEOUT == 1) ? ST_FORCE : ST_WAIT;
          cnt_nxt_s   = (TIMEOUT != 0) ? CW'(1) : {CW{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end
      end
      ST_WAIT: begin
        if (O_wb_ack || !I_wb_stb) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end else if (I_wb_adr != adr_r) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = {CW{1'b0}};
        end else if ((TIMEOUT != 0) && (cnt_r == TO_LAST)) begin
          state_nxt_s = ST_FORCE;
          cnt_nxt_s   = {CW{1'b0}};
        end else if (TIMEOUT != 0) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = cnt_r + CW'(1);
        end else begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_FORCE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter, address history and error capture registers.
  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      adr_r       <= 32'h0;
      err_r       <= 1'b0;
      err_count_r <= 8'h00;
      err_adr_r   <= 32'h0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      adr_r   <= I_wb_adr;
      err_r   <= err_resp_s;
      if (err_resp_s) begin
        err_count_r <= (err_count_r == 8'hFF) ? 8'hFF : err_count_r + 8'd1;
        err_adr_r   <= I_wb_adr;
      end else begin
        err_count_r <= err_count_r;
        err_adr_r   <= err_adr_r;
      end
    end
  end

endmodule

// File: tb/tb_wb8_slave_mux.sv
// Directed bench for wb8_slave_mux: two instances share address and slave
// buses. Instance A ACKs unmapped addresses in the same cycle. Instance B
// leaves unmapped addresses to the timeout.
module tb_wb8_slave_mux;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic        stb_a;
  logic        stb_b;
  logic [23:0] sdat;
  logic [2:0]  sack;

  logic [7:0]  dat_a, dat_b;
  logic        ack_a, ack_b;
  logic [2:0]  sstb_a, sstb_b;
  logic        err_a, err_b;
  logic [7:0]  errc_a, errc_b;
  logic [31:0] erra_a, erra_b;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [95:0] TB_BASES = {32'h00001000, 32'hFFFF0000, 32'hFFFF0000};
  localparam logic [95:0] TB_MASKS = {32'hFFFFF000, 32'hFFFF0000, 32'hFFFFE000};

  wb8_slave_mux #(
    .NSLAVES(3), .BASES(TB_BASES), .MASKS(TB_MASKS),
    .TIMEOUT(8), .UNMAPPED_ACK(1'b1), .DEFAULT_DAT(8'h3C)
  ) u_dut_a (
    .I_wb_clk(clk), .I_reset(rst), .I_wb_adr(adr), .I_wb_stb(stb_a),
    .O_wb_dat(dat_a), .O_wb_ack(ack_a), .O_slv_stb(sstb_a),
    .I_slv_dat(sdat), .I_slv_ack(sack),
    .O_err(err_a), .O_err_count(errc_a), .O_err_adr(erra_a)
  );

  wb8_slave_mux #(
    .NSLAVES(3), .BASES(TB_BASES), .MASKS(TB_MASKS),
    .TIMEOUT(8), .UNMAPPED_ACK(1'b0), .DEFAULT_DAT(8'hC3)
  ) u_dut_b (
    .I_wb_clk(clk), .I_reset(rst), .I_wb_adr(adr), .I_wb_stb(stb_b),
    .O_wb_dat(dat_b), .O_wb_ack(ack_b), .O_slv_stb(sstb_b),
    .I_slv_dat(sdat), .I_slv_ack(sack),
    .O_err(err_b), .O_err_count(errc_b), .O_err_adr(erra_b)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 unit later.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stb_a = 1'b0; stb_b = 1'b0;
    adr = 32'h0; sdat = 24'h0; sack = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_ack", {31'h0, ack_a}, 32'h0);
    chk_eq("rst_stb", {29'h0, sstb_a}, 32'h0);
    chk_eq("rst_err", {31'h0, err_a}, 32'h0);
    chk_eq("rst_cnt", {24'h0, errc_a}, 32'h0);
    chk_eq("rst_adr", erra_a, 32'h0);

    // Overlapping maps: FFFF0010 matches slaves 0 and 1, and slave 0 wins.
    rst = 1'b0; adr = 32'hFFFF0010; stb_a = 1'b1;
    sdat = {8'h33, 8'h22, 8'h11}; sack = 3'b001;
    #1;
    chk_eq("ovl_stb", {29'h0, sstb_a}, 32'h1);
    chk_eq("ovl_dat", {24'h0, dat_a}, 32'h11);
    chk_eq("ovl_ack", {31'h0, ack_a}, 32'h1);
    // FFFF4000 falls outside slave 0, so it goes to slave 1, and an ACK from slave 0 is ignored.
    next_cyc(); adr = 32'hFFFF4000; sack = 3'b001; #1;
    chk_eq("s1_stb", {29'h0, sstb_a}, 32'h2);
    chk_eq("s1_ign_ack", {31'h0, ack_a}, 32'h0);
    next_cyc(); sack = 3'b010; #1;
    chk_eq("s1_ack", {31'h0, ack_a}, 32'h1);
    chk_eq("s1_dat", {24'h0, dat_a}, 32'h22);
    next_cyc(); adr = 32'h00001234; sack = 3'b100; #1;
    chk_eq("s2_stb", {29'h0, sstb_a}, 32'h4);
    chk_eq("s2_dat", {24'h0, dat_a}, 32'h33);
    next_cyc(); stb_a = 1'b0; sack = 3'b000; #1;
    chk_eq("map_no_err", {31'h0, err_a}, 32'h0);

    // Slave 2 ACKs on the 4th STB cycle with A5.
    next_cyc(); adr = 32'h00001234; stb_a = 1'b1; sdat = {8'hA5, 8'h22, 8'h77}; #1;
    for (int k = 1; k <= 3; k++) begin
      chk_eq($sformatf("slow_ack_c%0d", k), {31'h0, ack_a}, 32'h0);
      chk_eq($sformatf("slow_stb_c%0d", k), {29'h0, sstb_a}, 32'h4);
      next_cyc(); #1;
    end
    sack = 3'b100; #1;
    chk_eq("slow_ack", {31'h0, ack_a}, 32'h1);
    chk_eq("slow_dat", {24'h0, dat_a}, 32'hA5);
    next_cyc(); stb_a = 1'b0; sack = 3'b000; #1;
    chk_eq("slow_err", {31'h0, err_a}, 32'h0);
    chk_eq("slow_cnt", {24'h0, errc_a}, 32'h0);

    // Slave 0 never ACKs, so the ACK is forced on cycle 9 and a late slave ACK is ignored.
    next_cyc(); adr = 32'hFFFF0020; stb_a = 1'b1; #1;
    for (int k = 1; k <= 8; k++) begin
      chk_eq($sformatf("to_ack_c%0d", k), {31'h0, ack_a}, 32'h0);
      next_cyc(); #1;
    end
    sack = 3'b001; #1;
    chk_eq("to_ack", {31'h0, ack_a}, 32'h1);
    chk_eq("to_dat", {24'h0, dat_a}, 32'h3C);
    chk_eq("to_stb", {29'h0, sstb_a}, 32'h0);
    next_cyc(); stb_a = 1'b0; sack = 3'b000; #1;
    chk_eq("to_err", {31'h0, err_a}, 32'h1);
    chk_eq("to_eadr", erra_a, 32'hFFFF0020);
    chk_eq("to_cnt", {24'h0, errc_a}, 32'h1);
    next_cyc(); #1;
    chk_eq("to_err_pulse", {31'h0, err_a}, 32'h0);

    // Instance A ACKs the unmapped address in the same cycle.
    adr = 32'h80001234; stb_a = 1'b1; #1;
    chk_eq("um_ack", {31'h0, ack_a}, 32'h1);
    chk_eq("um_dat", {24'h0, dat_a}, 32'h3C);
    chk_eq("um_stb", {29'h0, sstb_a}, 32'h0);
    next_cyc(); stb_a = 1'b0; #1;
    chk_eq("um_err", {31'h0, err_a}, 32'h1);
    chk_eq("um_cnt", {24'h0, errc_a}, 32'h2);
    chk_eq("um_eadr", erra_a, 32'h80001234);

    // Instance B: the same unmapped address times out.
    next_cyc(); stb_b = 1'b1; #1;
    for (int k = 1; k <= 8; k++) begin
      chk_eq($sformatf("umb_ack_c%0d", k), {31'h0, ack_b}, 32'h0);
      next_cyc(); #1;
    end
    chk_eq("umb_ack", {31'h0, ack_b}, 32'h1);
    chk_eq("umb_dat", {24'h0, dat_b}, 32'hC3);
    next_cyc(); stb_b = 1'b0; #1;
    chk_eq("umb_err", {31'h0, err_b}, 32'h1);
    chk_eq("umb_cnt", {24'h0, errc_b}, 32'h1);

    // 300 back-to-back unmapped accesses: the count saturates.
    for (int i = 0; i < 300; i++) begin
      next_cyc(); adr = 32'h80000000 + 32'(i); stb_a = 1'b1; #1;
      if (i == 0 || i == 299) chk_eq($sformatf("sat_ack_%0d", i), {31'h0, ack_a}, 32'h1);
      if (i == 100) chk_eq("sat_cnt_100", {24'h0, errc_a}, 32'h66);
      if (i == 254) chk_eq("sat_cnt_254", {24'h0, errc_a}, 32'hFF);
    end
    next_cyc(); stb_a = 1'b0; #1;
    chk_eq("sat_cnt", {24'h0, errc_a}, 32'hFF);
    chk_eq("sat_eadr", erra_a, 32'h8000012B);

    // Reset during WAIT cycle 5 aborts without an ACK.
    next_cyc(); adr = 32'hFFFF0030; stb_a = 1'b1; #1;
    for (int k = 1; k <= 5; k++) begin
      chk_eq($sformatf("ra_ack_c%0d", k), {31'h0, ack_a}, 32'h0);
      next_cyc(); #1;
    end
    rst = 1'b1; stb_a = 1'b0; #1;
    chk_eq("ra_ack_rst", {31'h0, ack_a}, 32'h0);
    next_cyc(); rst = 1'b0; #1;
    chk_eq("ra_cnt", {24'h0, errc_a}, 32'h0);
    chk_eq("ra_err", {31'h0, err_a}, 32'h0);
    chk_eq("ra_eadr", erra_a, 32'h0);
    // The next access still needs the full timeout.
    next_cyc(); adr = 32'hFFFF0040; stb_a = 1'b1; #1;
    for (int k = 1; k <= 8; k++) begin
      chk_eq($sformatf("ra2_ack_c%0d", k), {31'h0, ack_a}, 32'h0);
      next_cyc(); #1;
    end
    chk_eq("ra2_ack", {31'h0, ack_a}, 32'h1);
    next_cyc(); stb_a = 1'b0; #1;
    chk_eq("ra2_cnt", {24'h0, errc_a}, 32'h1);
    chk_eq("ra2_eadr", erra_a, 32'hFFFF0040);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
